// File: rtl/stop_watch_ctrl.sv
// Stopwatch control FSM: turns button levels into run/pause/lap/clear control,
// generates the counter tick and clear pulse, and muxes live vs. lap display digits.
module stop_watch_ctrl #(
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  input  logic [3:0] cnt_d0,
  input  logic [3:0] cnt_d1,
  input  logic [3:0] cnt_d2,
  input  logic [3:0] cnt_d3,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [3:0] disp_d0,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d3,
  output logic       running,
  output logic       lap_active
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    LAP_RUN = 2'd2,
    PAUSE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] presc, presc_nxt;
  logic             clr_nxt;
  logic             lap_cap;
  logic             ss_prev, lap_prev, clr_prev;
  logic             ss_press, lap_press, clr_press;
  logic [3:0]       lap_d0, lap_d1, lap_d2, lap_d3;
  logic             counting;

  // Edge registers reset high so a button held through reset release is not a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ss_prev  <= 1'b1;
      lap_prev <= 1'b1;
      clr_prev <= 1'b1;
    end else begin
      ss_prev  <= start_stop;
      lap_prev <= lap;
      clr_prev <= clear;
    end
  end

  assign ss_press  = start_stop & ~ss_prev;
  assign lap_press = lap & ~lap_prev;
  assign clr_press = clear & ~clr_prev;

  assign counting   = (state == RUN) || (state == LAP_RUN);
  assign running    = counting;
  assign lap_active = (state == LAP_RUN);
  assign cnt_en     = counting && (presc == TICK_MAX);

  always_comb begin
    state_nxt = state;
    clr_nxt   = 1'b0;
    lap_cap   = 1'b0;
    presc_nxt = presc;
    if (counting) begin
      presc_nxt = (presc == TICK_MAX) ? '0 : presc + 1'b1;
    end
    unique case (state)
      IDLE: begin
        if (ss_press) begin
          state_nxt = RUN;
        end else if (clr_press) begin
          clr_nxt = 1'b1;
        end
      end
      RUN: begin
        if (ss_press) begin
          state_nxt = PAUSE;
        end else if (lap_press) begin
          state_nxt = LAP_RUN;
          lap_cap   = 1'b1;
        end
      end
      LAP_RUN: begin
        if (ss_press) begin
          state_nxt = PAUSE;
        end else if (lap_press) begin
          state_nxt = RUN;
        end
      end
      PAUSE: begin
        if (clr_press) begin
          state_nxt = IDLE;
          clr_nxt   = 1'b1;
          presc_nxt = '0;
        end else if (ss_press) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      presc   <= '0;
      cnt_clr <= 1'b0;
    end else begin
      state   <= state_nxt;
      presc   <= presc_nxt;
      cnt_clr <= clr_nxt;
    end
  end

  // Lap capture survives clear; only reset or the next capture changes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lap_d0 <= '0;
      lap_d1 <= '0;
      lap_d2 <= '0;
      lap_d3 <= '0;
    end else if (lap_cap) begin
      lap_d0 <= cnt_d0;
      lap_d1 <= cnt_d1;
      lap_d2 <= cnt_d2;
      lap_d3 <= cnt_d3;
    end
  end

  assign disp_d0 = lap_active ? lap_d0 : cnt_d0;
  assign disp_d1 = lap_active ? lap_d1 : cnt_d1;
  assign disp_d2 = lap_active ? lap_d2 : cnt_d2;
  assign disp_d3 = lap_active ? lap_d3 : cnt_d3;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Directed bench for stop_watch_ctrl with TICK_DIV=4; inputs change and outputs
// are sampled 1 time unit after each rising clock edge.
module tb_stop_watch_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_stop, lap, clear;
  logic [3:0] cnt_d0, cnt_d1, cnt_d2, cnt_d3;
  logic       cnt_en, cnt_clr, running, lap_active;
  logic [3:0] disp_d0, disp_d1, disp_d2, disp_d3;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  int unsigned pulses;

  stop_watch_ctrl #(.TICK_DIV(4), .CNT_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .cnt_d0     (cnt_d0),
    .cnt_d1     (cnt_d1),
    .cnt_d2     (cnt_d2),
    .cnt_d3     (cnt_d3),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .disp_d0    (disp_d0),
    .disp_d1    (disp_d1),
    .disp_d2    (disp_d2),
    .disp_d3    (disp_d3),
    .running    (running),
    .lap_active (lap_active)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] disp();
    return {disp_d3, disp_d2, disp_d1, disp_d0};
  endfunction

  initial begin
    reset = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    {cnt_d3, cnt_d2, cnt_d1, cnt_d0} = 16'h0000;
    step(); step();
    check("rst_running", running, 0);
    check("rst_lap", lap_active, 0);
    check("rst_en", cnt_en, 0);
    check("rst_clr", cnt_clr, 0);
    reset = 1'b0;
    step();

    // IDLE: clear pulses, lap ignored
    clear = 1'b1; step(); clear = 1'b0;
    check("idle_clr", cnt_clr, 1);
    step();
    check("idle_clr_one", cnt_clr, 0);
    lap = 1'b1; step(); lap = 1'b0;
    check("idle_lap_ign", lap_active, 0);
    check("idle_lap_run", running, 0);

    // Test 1: start, 5 ticks in 20 RUN cycles on every 4th
    start_stop = 1'b1; step(); start_stop = 1'b0;
    check("t1_running", running, 1);
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      check($sformatf("t1_en_%0d", i), cnt_en, (i % 4 == 0));
      if (cnt_en) pulses++;
      step();
    end
    check("t1_pulses", pulses, 5);

    // Test 2: pause two cycles past a tick, resume keeps phase
    step();
    start_stop = 1'b1; step(); start_stop = 1'b0;
    check("t2_paused", running, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (cnt_en) pulses++;
      step();
    end
    check("t2_no_en_pause", pulses, 0);
    start_stop = 1'b1; step(); start_stop = 1'b0;
    check("t2_resume_run", running, 1);
    check("t2_en_r1", cnt_en, 0);
    step();
    check("t2_en_r2", cnt_en, 1);
    step();

    // Test 3: lap freeze and release
    {cnt_d3, cnt_d2, cnt_d1, cnt_d0} = 16'h0123;
    lap = 1'b1; step(); lap = 1'b0;
    check("t3_lap_on", lap_active, 1);
    check("t3_disp_cap", disp(), 16'h0123);
    cnt_d0 = 4'd9;
    #1;
    check("t3_disp_frozen", disp(), 16'h0123);
    step(); step();
    check("t3_en_lap", cnt_en, 1);
    check("t3_still_frozen", disp(), 16'h0123);
    step();
    lap = 1'b1; step(); lap = 1'b0;
    check("t3_lap_off", lap_active, 0);
    check("t3_disp_live", disp(), 16'h0129);
    check("t3_run", running, 1);

    // Test 4: clear ignored in RUN, honoured in PAUSE
    clear = 1'b1; step(); clear = 1'b0;
    check("t4_clr_run", cnt_clr, 0);
    check("t4_run_kept", running, 1);
    start_stop = 1'b1; step(); start_stop = 1'b0;
    check("t4_paused", running, 0);
    clear = 1'b1; step(); clear = 1'b0;
    check("t4_clr_pulse", cnt_clr, 1);
    check("t4_idle", running, 0);
    step();
    check("t4_clr_one", cnt_clr, 0);
    check("t4_idle2", running, 0);
    start_stop = 1'b1; step(); start_stop = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t4_en_%0d", i), cnt_en, (i == 4));
      step();
    end

    // Test 5: simultaneous presses
    start_stop = 1'b1; lap = 1'b1; step(); start_stop = 1'b0; lap = 1'b0;
    check("t5_pause", running, 0);
    check("t5_nolap", lap_active, 0);
    start_stop = 1'b1; clear = 1'b1; step(); start_stop = 1'b0; clear = 1'b0;
    check("t5_clr", cnt_clr, 1);
    check("t5_idle", running, 0);
    step();
    check("t5_clr_one", cnt_clr, 0);
    check("t5_idle2", running, 0);

    // Test 6: async reset mid-RUN with start_stop held
    start_stop = 1'b1; step();
    check("t6_run", running, 1);
    step(); step();
    #2 reset = 1'b1;
    #1;
    check("t6_async_run", running, 0);
    check("t6_async_en", cnt_en, 0);
    check("t6_async_lap", lap_active, 0);
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    check("t6_held_idle", running, 0);
    start_stop = 1'b0; step();
    start_stop = 1'b1; step();
    check("t6_repress", running, 1);
    step();
    check("t6_hold_one", running, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
